regs_ctrl: RTL

- Request-side controller for the pMIPS 32 x n register file (regs). It drives both regs ports, meaning the addresses Raddr1/Raddr2, write enables w1/w2 and Wdata1/Wdata2, and returns Rdata1/Rdata2 as a response.
- It sits between the decode/writeback logic and regs. It accepts read and write requests over a valid/ready handshake.
- It provides a CLEAR sequence that zeroes registers 1..31 using both write ports.
- Regs semantics it targets:
  - Port k writes Wdatak to address Raddrk on a clock edge when wk=1.
  - Reads are synchronous, so Rdatak is valid the cycle after the address is presented.
  - Register %0 always reads 0.

---
 rtl/regs_ctrl_pkg.sv | 32 +++
 rtl/regs_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/regs_ctrl_pkg.sv
// Shared types and constants for the pMIPS register-file request controller.
package regs_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int NREGS     = 32;
  localparam int CLR_STEPS = 16;

  // Port-1 address driven at CLEAR step i: odd registers 1,3,..,31.
  function automatic logic [4:0] clr_addr1(input logic [3:0] step);
    return {step, 1'b1};
  endfunction

  // Port-2 address driven at CLEAR step i: even registers 2,4,..,30; the
  // final step has no even partner (register 32 does not exist).
  function automatic logic [4:0] clr_addr2(input logic [3:0] step);
    logic [3:0] nxt;
    nxt = step + 4'd1;
    return (step == 4'(CLR_STEPS - 1)) ? 5'd0 : {nxt, 1'b0};
  endfunction

endpackage

// File: rtl/regs_ctrl.sv
// Request-side controller for the pMIPS 32 x n register file.
// Accepts READ/WRITE/NOP/CLEAR requests over valid/ready, drives both regs
// ports from registers, and returns read data two cycles after acceptance.
module regs_ctrl
  import regs_ctrl_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [4:0]   req_a1,
  input  logic [4:0]   req_a2,
  input  logic [n-1:0] req_d1,
  input  logic [n-1:0] req_d2,
  input  logic         req_we1,
  input  logic         req_we2,
  output logic         rsp_valid,
  output logic [n-1:0] rsp_d1,
  output logic [n-1:0] rsp_d2,
  output logic         busy,
  output logic         clr_done,
  output logic [4:0]   Raddr1,
  output logic [4:0]   Raddr2,
  output logic         w1,
  output logic         w2,
  output logic [n-1:0] Wdata1,
  output logic [n-1:0] Wdata2,
  input  logic [n-1:0] Rdata1,
  input  logic [n-1:0] Rdata2
);

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_rd_pend;
  logic         r_rsp_valid;
  logic         r_busy;
  logic         r_clr_done;
  logic [4:0]   r_raddr1, r_raddr2;
  logic         r_w1, r_w2;
  logic [n-1:0] r_wdata1, r_wdata2;

  op_t          w_op;
  logic         w_acc;
  logic         w_last;
  logic [3:0]   w_cnt_nxt;
  logic         w_w2_ok;

  assign w_op      = op_t'(req_op);
  assign req_ready = (r_state == IDLE) & nReset;
  assign w_acc     = req_valid & req_ready;
  assign w_last    = (r_cnt == 4'(CLR_STEPS - 1));
  assign w_cnt_nxt = r_cnt + 4'd1;
  // Port 1 wins a same-address double write.
  assign w_w2_ok   = req_we2 & ~(req_we1 & (req_a1 == req_a2));

  // Main FSM: request decode, CLEAR walker and response timing.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rd_pend   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_clr_done  <= 1'b0;
      r_raddr1    <= '0;
      r_raddr2    <= '0;
      r_w1        <= 1'b0;
      r_w2        <= 1'b0;
      r_wdata1    <= '0;
      r_wdata2    <= '0;
    end else begin
      // Write strobes and pulses are single-cycle unless re-armed below.
      r_w1        <= 1'b0;
      r_w2        <= 1'b0;
      r_clr_done  <= 1'b0;
      r_rd_pend   <= 1'b0;
      // regs returns data one cycle after the address, so the response
      // qualifier trails the pending flag by one cycle.
      r_rsp_valid <= r_rd_pend;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            case (w_op)
              OP_READ: begin
                r_raddr1  <= req_a1;
                r_raddr2  <= req_a2;
                r_rd_pend <= 1'b1;
              end
              OP_WRITE: begin
                r_raddr1 <= req_a1;
                r_raddr2 <= req_a2;
                r_wdata1 <= req_d1;
                r_wdata2 <= req_d2;
                r_w1     <= req_we1;
                r_w2     <= w_w2_ok;
              end
              OP_CLEAR: begin
                r_state  <= CLEAR;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_raddr1 <= clr_addr1(4'd0);
                r_raddr2 <= clr_addr2(4'd0);
                r_wdata1 <= '0;
                r_wdata2 <= '0;
                r_w1     <= 1'b1;
                r_w2     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          if (w_last) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_raddr1 <= clr_addr1(w_cnt_nxt);
            r_raddr2 <= clr_addr2(w_cnt_nxt);
            r_w1     <= 1'b1;
            r_w2     <= (w_cnt_nxt != 4'(CLR_STEPS - 1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_d1    = Rdata1;
  assign rsp_d2    = Rdata2;
  assign busy      = r_busy;
  assign clr_done  = r_clr_done;
  assign Raddr1    = r_raddr1;
  assign Raddr2    = r_raddr2;
  assign w1        = r_w1;
  assign w2        = r_w2;
  assign Wdata1    = r_wdata1;
  assign Wdata2    = r_wdata2;

endmodule
